array_mult_seq: RTL
===================

ARRAY_MULT_SEQ -- requirements
Module: array_mult_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the completed-result counter.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  operand pair offered.
REQ-005 SHALL have port in_ready  output  1  block accepts operand pair this cycle.
REQ-006 SHALL have port in_m  input  4  multiplicand.
REQ-007 SHALL have port in_q  input  4  multiplier.
REQ-008 SHALL have port mult_m  output  4  registered multiplicand to external array multiplier.
REQ-009 SHALL have port mult_q  output  4  registered multiplier to external array multiplier.
REQ-010 SHALL have port mult_p  input  8  combinational product returned by array multiplier.
REQ-011 SHALL have port out_valid  output  1  result held on out_p.
REQ-012 SHALL have port out_ready  input  1  consumer takes result.
REQ-013 SHALL have port out_p  output  12  registered result (product or running sum).
REQ-014 SHALL have port acc_clr  input  1  accumulator clear request.
REQ-015 SHALL have port acc_ovf  output  1  sticky accumulator overflow.
REQ-016 SHALL have port result_cnt  output  CNT_W  count of completed output handshakes.
REQ-017 SHALL have one clock, clk; reset rst_n is asynchronous and active-low.

Function
REQ-018 SHALL implement FSM states IDLE, CALC, DONE.
REQ-019 SHALL assert in_ready in IDLE, and in DONE only when out_ready=1; deassert in CALC.
REQ-020 SHALL, on in_valid&&in_ready, register in_m/in_q into mult_m/mult_q and enter CALC.
REQ-021 SHALL in CALC sample mult_p at the next edge into out_p (zero-extended, or summed per REQ-030) and enter DONE.
REQ-022 SHALL hold out_valid=1 in DONE only; out_p and mult_m/mult_q stable while out_valid=1 and out_ready=0.
REQ-023 SHALL on out_valid&&out_ready leave DONE: to CALC if in_valid also high (new operands captured same edge), else IDLE.
REQ-024 SHALL give latency of 2 edges from accept to out_valid; peak throughput one result per 2 cycles.
REQ-025 SHALL increment result_cnt by 1 per output handshake, wrapping modulo 2^CNT_W.
REQ-026 SHALL ignore in_m/in_q/in_valid changes while in_ready=0.

Reset
REQ-027 SHALL on rst_n=0 immediately force state IDLE, mult_m=0, mult_q=0, out_p=0, out_valid=0, acc_ovf=0, result_cnt=0, accumulator=0, regardless of state (including mid-CALC/DONE; in-flight result discarded).
REQ-028 SHALL drive in_ready=1 in the first cycle after rst_n deasserts.

Configuration
REQ-029 SHALL compile accumulate mode only when macro ARRAY_MULT_SEQ_ACC_EN is defined.
REQ-030 With ARRAY_MULT_SEQ_ACC_EN: CALC capture adds mult_p to a 12-bit accumulator, out_p = new sum; carry out of bit 11 sets acc_ovf (sticky) and sum wraps modulo 4096.
REQ-031 With ARRAY_MULT_SEQ_ACC_EN: acc_clr=1 at any edge zeroes accumulator and acc_ovf; if coincident with a CALC capture, result = mult_p (clear first, then add).
REQ-032 Without ARRAY_MULT_SEQ_ACC_EN: out_p = {4'b0, mult_p}, acc_clr ignored, acc_ovf tied 0.

Structure
REQ-033 SHALL take from shared package mult_pkg: state enum (IDLE/CALC/DONE), OPND_W=4, PROD_W=8, ACC_W=12.
REQ-034 SHALL not instantiate the multiplier internally; natural sub-module array_mult_structural is instantiated alongside at parent level via mult_m/mult_q/mult_p.
REQ-035 Bench SHALL connect array_mult_structural to mult_* ports.

Verification
REQ-036 Reset then m=3,q=12 accepted, out_ready=1 -> out_valid 2 edges later, out_p=36, result_cnt=1.
REQ-037 m=15,q=15 with out_ready=0 for 5 cycles -> out_p=225 held, in_ready=0, then release -> one handshake only.
REQ-038 Back-to-back: 5x10 then 7x7 with in_valid and out_ready held high -> out_p 50 then 49 on consecutive DONE cycles, 2-cycle spacing.
REQ-039 rst_n pulsed low during CALC of 8x8 -> outputs zero asynchronously, no out_valid for that pair, result_cnt=0.
REQ-040 ACC_EN: acc_clr, then 19 pairs of 15x15 -> out_p wraps after 19th (4275 mod 4096 = 179), acc_ovf=1; acc_clr -> acc_ovf=0.
REQ-041 result_cnt with CNT_W=8 after 256 handshakes of 1x1 -> wraps to 0.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: shared widths and FSM state type for the sequential array-multiplier wrapper.
// Contents: OPND_W (operand width), PROD_W (product width), ACC_W (result/accumulator width), state_t.
package mult_pkg;
    localparam int OPND_W = 4;
    localparam int PROD_W = 8;
    localparam int ACC_W  = 12;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/array_mult_structural.sv
// array_mult_structural: combinational 4x4 array multiplier built as shifted partial-product rows.
// Ports: m_i multiplicand, q_i multiplier, p_o product.
module array_mult_structural
    import mult_pkg::*;
(
    input  logic [OPND_W-1:0] m_i,
    input  logic [OPND_W-1:0] q_i,
    output logic [PROD_W-1:0] p_o
);
    logic [PROD_W-1:0] row [OPND_W+1];
    assign row[0] = '0;
    for (genvar i = 0; i < OPND_W; i++) begin : g_row
        assign row[i+1] = row[i] + ({{(PROD_W-OPND_W){1'b0}}, m_i & {OPND_W{q_i[i]}}} << i);
    end
    assign p_o = row[OPND_W];
endmodule

// File: rtl/array_mult_seq.sv
// array_mult_seq: handshaked sequencer that feeds an external array multiplier and registers its product.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_m/in_q operand handshake;
// mult_m/mult_q/mult_p external multiplier link; out_valid/out_ready/out_p result handshake;
// acc_clr/acc_ovf accumulator control and sticky overflow; result_cnt completed handshakes.
// Define ARRAY_MULT_SEQ_ACC_EN to make out_p a running 12-bit sum of products.
module array_mult_seq
    import mult_pkg::*;
#(
    parameter int CNT_W = 8
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] in_m,
    input  logic [OPND_W-1:0] in_q,
    output logic [OPND_W-1:0] mult_m,
    output logic [OPND_W-1:0] mult_q,
    input  logic [PROD_W-1:0] mult_p,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_p,
    input  logic              acc_clr,
    output logic              acc_ovf,
    output logic [CNT_W-1:0]  result_cnt
);
    state_t            state_q;
    logic [OPND_W-1:0] mult_m_q, mult_q_q;
    logic [ACC_W-1:0]  out_p_q, res_d;
    logic              out_valid_q, acc_ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept, hs;

    // DONE may take new operands in the same cycle its result leaves
    assign in_ready = state_q == IDLE || (state_q == DONE && out_ready);
    assign accept   = in_valid && in_ready;
    assign hs       = out_valid_q && out_ready;

`ifdef ARRAY_MULT_SEQ_ACC_EN
    logic [ACC_W-1:0] acc_q, acc_base;
    logic [ACC_W:0]   sum;
    // clear takes effect before a coincident add
    assign acc_base = acc_clr ? '0 : acc_q;
    assign sum      = {1'b0, acc_base} + {{(ACC_W+1-PROD_W){1'b0}}, mult_p};
    assign res_d    = sum[ACC_W-1:0];
    assign ovf_d    = (!acc_clr && acc_ovf_q) || (state_q == CALC && sum[ACC_W]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (state_q == CALC) begin
            acc_q <= res_d;
        end else if (acc_clr) begin
            acc_q <= '0;
        end
    end
`else
    logic unused_acc_clr;
    assign unused_acc_clr = acc_clr;
    assign res_d          = {{(ACC_W-PROD_W){1'b0}}, mult_p};
    assign ovf_d          = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mult_m_q    <= '0;
            mult_q_q    <= '0;
            out_p_q     <= '0;
            out_valid_q <= 1'b0;
            acc_ovf_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            acc_ovf_q <= ovf_d;
            if (hs) cnt_q <= cnt_q + 1'b1;
            if (accept) begin
                mult_m_q <= in_m;
                mult_q_q <= in_q;
            end
            case (state_q)
                IDLE: if (accept) state_q <= CALC;
                CALC: begin
                    out_p_q     <= res_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= in_valid ? CALC : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mult_m     = mult_m_q;
    assign mult_q     = mult_q_q;
    assign out_p      = out_p_q;
    assign out_valid  = out_valid_q;
    assign acc_ovf    = acc_ovf_q;
    assign result_cnt = cnt_q;
endmodule
